sd_cmd_engine: RTL
==================

# sd_cmd_engine

Hardware SD-card command-line engine. It replaces software bit-banging of the SD CMD pin with an Avalon-MM slave that serialises 48-bit command frames with generated CRC7. It also generates the SD clock and captures and checks 48-bit responses. It sits between the Nios II data bus and the SD card's CMD/CLK pins, in the position the CMD PIO occupies today.

## Interface
Parameters
- CLK_DIV, 4: half-period of sd_clk in clk cycles (≥2).
- RESP_TIMEOUT, 64: sd_clk rising edges to wait for a response start bit before flagging timeout.

Ports
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- address  in  3  register select.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- sd_clk  out  1  SD clock to card.
- sd_cmd  inout  1  SD CMD line; driven only while transmitting, else high-Z.

## Operation
Register map (reads return 0 in unused bits):
- addr 0 ARG (R/W): 32-bit command argument.
- addr 1 CMD (W):
  - [5:0] command index; [8] resp_en.
  - A write while idle starts a command.
  - A write while busy is ignored.
- addr 2 STATUS (R): [0] busy, [1] done, [2] timeout, [3] crc_err, [4] end_err. Bits [1]–[4] clear when a command starts.
- addr 3 RESP (R): captured response bits [39:8], the 32-bit payload.
- addr 4 RESP_IDX (R): [5:0] captured response bits [45:40].

SD clock:
- Free-running from reset release.
- Low for CLK_DIV clk, then high for CLK_DIV clk.
- Internal rise_tick marks the clk cycle sd_clk goes high; fall_tick marks the cycle it goes low.
- TX changes sd_cmd on fall_tick; RX samples sd_cmd on rise_tick.

TX frame, MSB first:
- start 0, transmission 1, index[5:0], ARG[31:0], CRC7, end 1.
- CRC7 polynomial x^7+x^3+1, init 0, computed over the first 40 bits.
- ARG and CMD are latched into the shift register at start. Later ARG writes do not affect the frame in flight.

State machine:
- IDLE: sd_cmd released; busy=0. A CMD write loads the frame, sets busy, and goes to TX_WAIT.
- TX_WAIT: on the next fall_tick, enable the driver, drive bit 47, go to TX.
- TX: shift one bit per fall_tick. On the fall_tick after bit 0 (end bit) has been driven for one full sd_clk, release the driver.
  - resp_en=0 → DONE.
  - resp_en=1 → clear the timeout counter, go to WAIT_RESP.
- WAIT_RESP: on each rise_tick, sample sd_cmd.
  - Sample 0 → store it as bit 47, go to RX.
  - Otherwise increment the counter. When it reaches RESP_TIMEOUT, set timeout and go to DONE.
- RX: shift in one bit per rise_tick until 48 bits are held, then check.
  - crc_err = 1 if the CRC7 of bits [47:8] ≠ bits [7:1].
  - end_err = 1 if bit 0 ≠ 1.
  - Update RESP and RESP_IDX, go to DONE. RESP and RESP_IDX change only here.
  - R3 responses carry CRC 1111111; software ignores crc_err for them.
- DONE: set done, clear busy, go to IDLE. This state lasts one clk cycle.

## Timing
- readdata is registered: valid the clk cycle after address is presented, regardless of chipselect. Read latency is 1.
- Command start: the first bit of the frame appears on the first fall_tick after busy rises; the wait is at most 2·CLK_DIV clk.
- Frame duration is 48·2·CLK_DIV clk. The driver is enabled for exactly 48 sd_clk periods.
- Earliest response detection is the first rise_tick after the driver releases.
- A write in the same cycle that busy drops is accepted only if the state is IDLE in that cycle. The DONE cycle ignores writes.
- Reset mid-operation returns the block, on the next clk edge, to:
  - IDLE, driver released, sd_clk low, divider 0;
  - ARG, CMD, RESP, RESP_IDX and STATUS all 0;
  - readdata 0.
- Reset values of outputs: readdata 0, sd_clk 0, sd_cmd high-Z.

## Test plan
- CMD0, ARG 0, resp_en 0 → sd_cmd carries 0x40_0000_0000_95 over 48 sd_clk, then high-Z; STATUS reads 0x2; busy high for the frame duration ±2·CLK_DIV.
- CMD8, ARG 0x000001AA, resp_en 1; bus-functional card model replies 0x08_0000_01AA_13 starting 2 sd_clk after release → frame 0x48_0000_01AA_87; RESP = 0x000001AA, RESP_IDX = 8, STATUS = 0x2.
- Same as above but the model never drives the line → timeout after 64 rise_ticks; STATUS = 0x6; RESP keeps its previous value.
- Model replies with one payload bit flipped → STATUS = 0xA; with end bit 0 → STATUS = 0x12.
- CMD write issued mid-frame, and an ARG write mid-frame → the in-flight frame is unchanged and no second command starts; ARG reads back the new value.
- reset_n low for one cycle mid-TX → sd_cmd is high-Z on the next cycle, STATUS = 0, sd_clk = 0; a fresh CMD0 afterwards transmits correctly.

Source files
------------

// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine
//   Avalon-MM slave that drives the SD CMD line in hardware. It generates a
//   free-running SD clock, sends 48-bit command frames with CRC7, and can
//   capture and check a 48-bit response.
//
// Ports
//   clk, reset_n        system clock, synchronous active-low reset
//   address[2:0]        register select: 0 ARG, 1 CMD, 2 STATUS, 3 RESP, 4 RESP_IDX
//   chipselect, write_n Avalon write qualifiers (write = chipselect & ~write_n)
//   writedata[31:0]     write data
//   readdata[31:0]      registered read data, one cycle after address
//   sd_clk              SD clock: CLK_DIV clk cycles low, then CLK_DIV clk cycles high
//   sd_cmd              SD CMD pin; driven only during a frame, otherwise high-Z
//
// Line handshake: the transmitter changes sd_cmd on the clk edge where sd_clk
// falls (fall_tick). The receiver samples sd_cmd on the clk edge where sd_clk
// rises (rise_tick). Each bit is therefore stable for half an sd_clk period
// on both sides of the sampling edge.
module sd_cmd_engine #(
  parameter int CLK_DIV      = 4,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        sd_clk,
  inout  wire         sd_cmd
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TO_W  = $clog2(RESP_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TX_WAIT, S_TX, S_WAIT_RESP, S_RX, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              sd_clk_q, sd_clk_d;
  logic [31:0]       arg_q, arg_d;
  logic              resp_en_q, resp_en_d;
  logic [47:0]       tx_sr_q, tx_sr_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic              cmd_oe_q, cmd_oe_d;
  logic [46:0]       rx_sr_q, rx_sr_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              crc_err_q, crc_err_d;
  logic              end_err_q, end_err_d;
  logic [31:0]       resp_q, resp_d;
  logic [5:0]        resp_idx_q, resp_idx_d;
  logic [31:0]       readdata_q, readdata_d;

  logic              div_wrap, rise_tick, fall_tick;
  logic              bus_wr, busy, cmd_in;
  logic [39:0]       frame40;
  logic [47:0]       rx_word;
  logic [TO_W-1:0]   to_next;

  // CRC7, polynomial x^7 + x^3 + 1, init 0, MSB first.
  function automatic logic [6:0] crc7(input logic [39:0] bits);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = bits[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  assign sd_cmd   = cmd_oe_q ? tx_sr_q[47] : 1'bz;
  assign cmd_in   = sd_cmd;
  assign sd_clk   = sd_clk_q;
  assign readdata = readdata_q;

  assign div_wrap  = (div_q == DIV_W'(CLK_DIV - 1));
  assign rise_tick = div_wrap & ~sd_clk_q;
  assign fall_tick = div_wrap & sd_clk_q;
  assign bus_wr    = chipselect & ~write_n;
  // The DONE cycle already reports not-busy so busy spans the frame itself.
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);

  always_comb begin
    state_d    = state_q;
    div_d      = div_wrap ? '0 : div_q + 1'b1;
    sd_clk_d   = div_wrap ? ~sd_clk_q : sd_clk_q;
    arg_d      = arg_q;
    resp_en_d  = resp_en_q;
    tx_sr_d    = tx_sr_q;
    bit_cnt_d  = bit_cnt_q;
    cmd_oe_d   = cmd_oe_q;
    rx_sr_d    = rx_sr_q;
    to_cnt_d   = to_cnt_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    crc_err_d  = crc_err_q;
    end_err_d  = end_err_q;
    resp_d     = resp_q;
    resp_idx_d = resp_idx_q;
    frame40    = {2'b01, writedata[5:0], arg_q};
    rx_word    = {rx_sr_q, cmd_in};
    to_next    = to_cnt_q + 1'b1;

    if (bus_wr && address == 3'd0) arg_d = writedata;

    case (state_q)
      S_IDLE: begin
        if (bus_wr && address == 3'd1) begin
          resp_en_d = writedata[8];
          tx_sr_d   = {frame40, crc7(frame40), 1'b1};
          done_d    = 1'b0;
          timeout_d = 1'b0;
          crc_err_d = 1'b0;
          end_err_d = 1'b0;
          state_d   = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        if (fall_tick) begin
          cmd_oe_d  = 1'b1;
          bit_cnt_d = 6'd47;
          state_d   = S_TX;
        end
      end
      S_TX: begin
        if (fall_tick) begin
          if (bit_cnt_q == 6'd0) begin
            // End bit has been on the line for a full sd_clk period.
            cmd_oe_d = 1'b0;
            to_cnt_d = '0;
            state_d  = resp_en_q ? S_WAIT_RESP : S_DONE;
          end else begin
            tx_sr_d   = {tx_sr_q[46:0], 1'b1};
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end
      end
      S_WAIT_RESP: begin
        if (rise_tick) begin
          if (!cmd_in) begin
            rx_sr_d   = '0;
            bit_cnt_d = 6'd1;
            state_d   = S_RX;
          end else begin
            to_cnt_d = to_next;
            if (to_next == TO_W'(RESP_TIMEOUT)) begin
              timeout_d = 1'b1;
              state_d   = S_DONE;
            end
          end
        end
      end
      S_RX: begin
        if (rise_tick) begin
          rx_sr_d = rx_word[46:0];
          if (bit_cnt_q == 6'd47) begin
            crc_err_d  = (crc7(rx_word[47:8]) != rx_word[7:1]);
            end_err_d  = ~rx_word[0];
            resp_d     = rx_word[39:8];
            resp_idx_d = rx_word[45:40];
            state_d    = S_DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    case (address)
      3'd0:    readdata_d = arg_q;
      3'd2:    readdata_d = {27'b0, end_err_q, crc_err_q, timeout_q, done_q, busy};
      3'd3:    readdata_d = resp_q;
      3'd4:    readdata_d = {26'b0, resp_idx_q};
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      sd_clk_q   <= 1'b0;
      arg_q      <= '0;
      resp_en_q  <= 1'b0;
      tx_sr_q    <= '0;
      bit_cnt_q  <= '0;
      cmd_oe_q   <= 1'b0;
      rx_sr_q    <= '0;
      to_cnt_q   <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      crc_err_q  <= 1'b0;
      end_err_q  <= 1'b0;
      resp_q     <= '0;
      resp_idx_q <= '0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      sd_clk_q   <= sd_clk_d;
      arg_q      <= arg_d;
      resp_en_q  <= resp_en_d;
      tx_sr_q    <= tx_sr_d;
      bit_cnt_q  <= bit_cnt_d;
      cmd_oe_q   <= cmd_oe_d;
      rx_sr_q    <= rx_sr_d;
      to_cnt_q   <= to_cnt_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      crc_err_q  <= crc_err_d;
      end_err_q  <= end_err_d;
      resp_q     <= resp_d;
      resp_idx_q <= resp_idx_d;
      readdata_q <= readdata_d;
    end
  end

endmodule
